// File: rtl/id_operand_fwd.sv
// ID-stage operand unit: resolves rs/rt over N_FWD forwarding sources, stalls on unready producers,
// and registers the result into the ID/EXE boundary. Optional stall counter under ID_STALL_CNT_EN.
module id_operand_fwd #(
    parameter int N_FWD = 3,
    parameter int DW    = 32,
    parameter int PCW   = 32
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PCW-1:0]       in_pc,
    input  logic [4:0]           in_rs,
    input  logic [4:0]           in_rt,
    input  logic                 in_use_rs,
    input  logic                 in_use_rt,
    input  logic                 in_is_jbr,
    input  logic [DW-1:0]        rf_rs_value,
    input  logic [DW-1:0]        rf_rt_value,
    input  logic [N_FWD-1:0]     fwd_wen,
    input  logic [5*N_FWD-1:0]   fwd_dest,
    input  logic [DW*N_FWD-1:0]  fwd_data,
    input  logic [N_FWD-1:0]     fwd_data_ok,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PCW-1:0]       out_pc,
    output logic [DW-1:0]        out_rs_value,
    output logic [DW-1:0]        out_rt_value,
    output logic                 out_in_delay,
`ifdef ID_STALL_CNT_EN
    output logic [31:0]          stall_cnt,
`endif
    output logic [DW-1:0]        fwd_rs_value,
    output logic [DW-1:0]        fwd_rt_value
);

    logic rs_hit, rs_ok, rt_hit, rt_ok;
    logic rs_wait, rt_wait, accept, delay_pend;

    // Scan oldest to youngest so the youngest matching source overwrites and wins.
    always_comb begin
        rs_hit       = 1'b0;
        rs_ok        = 1'b1;
        rt_hit       = 1'b0;
        rt_ok        = 1'b1;
        fwd_rs_value = rf_rs_value;
        fwd_rt_value = rf_rt_value;
        for (int i = N_FWD - 1; i >= 0; i--) begin
            if (fwd_wen[i] && (fwd_dest[5*i +: 5] == in_rs) && (in_rs != 5'd0)) begin
                rs_hit       = 1'b1;
                rs_ok        = fwd_data_ok[i];
                fwd_rs_value = fwd_data[DW*i +: DW];
            end
            if (fwd_wen[i] && (fwd_dest[5*i +: 5] == in_rt) && (in_rt != 5'd0)) begin
                rt_hit       = 1'b1;
                rt_ok        = fwd_data_ok[i];
                fwd_rt_value = fwd_data[DW*i +: DW];
            end
        end
        if (in_rs == 5'd0) fwd_rs_value = '0;
        if (in_rt == 5'd0) fwd_rt_value = '0;
    end

    assign rs_wait  = in_use_rs & rs_hit & ~rs_ok;
    assign rt_wait  = in_use_rt & rt_hit & ~rt_ok;
    assign in_ready = ~rs_wait & ~rt_wait & (~out_valid | out_ready) & ~flush;
    assign accept   = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            out_valid    <= 1'b0;
            out_pc       <= '0;
            out_rs_value <= '0;
            out_rt_value <= '0;
            out_in_delay <= 1'b0;
            delay_pend   <= 1'b0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            delay_pend <= 1'b0;
        end else if (accept) begin
            out_valid    <= 1'b1;
            out_pc       <= in_pc;
            out_rs_value <= fwd_rs_value;
            out_rt_value <= fwd_rt_value;
            out_in_delay <= delay_pend;
            delay_pend   <= in_is_jbr;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef ID_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (!resetn)
            stall_cnt <= '0;
        else if (in_valid && (rs_wait || rt_wait) && !flush)
            stall_cnt <= stall_cnt + 32'd1;
    end
`endif

endmodule

// File: tb/tb_id_operand_fwd.sv
// Bench for id_operand_fwd: directed scenarios with literal expectations plus randomized
// traffic checked every cycle against a behavioural model.
module tb_id_operand_fwd;
    localparam int N = 3;

    logic        clk = 1'b0;
    logic        resetn, in_valid, in_ready, in_use_rs, in_use_rt, in_is_jbr, flush;
    logic [31:0] in_pc, rf_rs_value, rf_rt_value;
    logic [4:0]  in_rs, in_rt;
    logic [N-1:0]    fwd_wen, fwd_data_ok;
    logic [5*N-1:0]  fwd_dest;
    logic [32*N-1:0] fwd_data;
    logic        out_valid, out_ready, out_in_delay;
    logic [31:0] out_pc, out_rs_value, out_rt_value, fwd_rs_value, fwd_rt_value;
`ifdef ID_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    always #5 clk = ~clk;

    id_operand_fwd #(.N_FWD(N), .DW(32), .PCW(32)) dut (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_rs(in_rs), .in_rt(in_rt), .in_use_rs(in_use_rs),
        .in_use_rt(in_use_rt), .in_is_jbr(in_is_jbr), .rf_rs_value(rf_rs_value),
        .rf_rt_value(rf_rt_value), .fwd_wen(fwd_wen), .fwd_dest(fwd_dest),
        .fwd_data(fwd_data), .fwd_data_ok(fwd_data_ok), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_rs_value(out_rs_value), .out_rt_value(out_rt_value),
        .out_in_delay(out_in_delay),
`ifdef ID_STALL_CNT_EN
        .stall_cnt(stall_cnt),
`endif
        .fwd_rs_value(fwd_rs_value), .fwd_rt_value(fwd_rt_value)
    );

    int total = 0;
    int bad   = 0;
    logic chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: first (youngest) matching source supplies the value.
    logic        m_valid, m_delay, m_pend;
    logic [31:0] m_pc, m_rs, m_rt, m_cnt;

    function automatic void resolve(input logic [4:0] r, input logic [31:0] rf,
                                    output logic [31:0] v, output logic blocked);
        logic found;
        found   = 1'b0;
        blocked = 1'b0;
        v       = (r == 5'd0) ? 32'd0 : rf;
        for (int i = 0; i < N; i++) begin
            if (!found && r != 5'd0 && fwd_wen[i] && fwd_dest[5*i +: 5] == r) begin
                found   = 1'b1;
                v       = fwd_data[32*i +: 32];
                blocked = ~fwd_data_ok[i];
            end
        end
    endfunction

    function automatic void model_comb(output logic [31:0] vrs, output logic [31:0] vrt,
                                       output logic stall, output logic rdy);
        logic brs, brt;
        resolve(in_rs, rf_rs_value, vrs, brs);
        resolve(in_rt, rf_rt_value, vrt, brt);
        stall = (in_use_rs & brs) | (in_use_rt & brt);
        rdy   = !stall && (!m_valid || out_ready) && !flush;
    endfunction

    always @(posedge clk) begin
        logic [31:0] vrs, vrt;
        logic stall, rdy;
        model_comb(vrs, vrt, stall, rdy);
        if (!resetn) begin
            m_valid = 0; m_pc = 0; m_rs = 0; m_rt = 0; m_delay = 0; m_pend = 0; m_cnt = 0;
        end else begin
            if (in_valid && stall && !flush) m_cnt = m_cnt + 1;
            if (flush) begin
                m_valid = 0; m_pend = 0;
            end else if (in_valid && rdy) begin
                m_valid = 1; m_pc = in_pc; m_rs = vrs; m_rt = vrt;
                m_delay = m_pend; m_pend = in_is_jbr;
            end else if (m_valid && out_ready) begin
                m_valid = 0;
            end
        end
    end

    always @(negedge clk) begin
        logic [31:0] vrs, vrt;
        logic stall, rdy;
        if (chk_en) begin
            model_comb(vrs, vrt, stall, rdy);
            chk("in_ready", 32'(in_ready), 32'(rdy));
            chk("fwd_rs_value", fwd_rs_value, vrs);
            chk("fwd_rt_value", fwd_rt_value, vrt);
            chk("out_valid", 32'(out_valid), 32'(m_valid));
            chk("out_pc", out_pc, m_pc);
            chk("out_rs_value", out_rs_value, m_rs);
            chk("out_rt_value", out_rt_value, m_rt);
            chk("out_in_delay", 32'(out_in_delay), 32'(m_delay));
`ifdef ID_STALL_CNT_EN
            chk("stall_cnt", stall_cnt, m_cnt);
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 0; in_pc = 0; in_rs = 0; in_rt = 0; in_use_rs = 0; in_use_rt = 0;
        in_is_jbr = 0; rf_rs_value = 32'h0bad_0001; rf_rt_value = 32'h0bad_0002;
        fwd_wen = 0; fwd_dest = 0; fwd_data = 0; fwd_data_ok = '1; flush = 0; out_ready = 1;
    endtask

    task automatic issue(input logic [31:0] pc, input logic jbr);
        in_valid = 1; in_pc = pc; in_is_jbr = jbr;
    endtask

    logic [31:0] cnt_snap;

    initial begin
        resetn = 0;
        idle();
        step(); step();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_pc", out_pc, 32'd0);
        chk("rst_out_rs", out_rs_value, 32'd0);
        chk("rst_out_rt", out_rt_value, 32'd0);
        chk("rst_out_in_delay", 32'(out_in_delay), 32'd0);
        resetn = 1;
        chk_en = 1;

        // Forward priority: EXE wins over MEM and WB
        issue(32'h200, 0); in_rs = 5; in_use_rs = 1;
        fwd_wen = 3'b111; fwd_dest = {5'd5, 5'd5, 5'd5};
        fwd_data = {32'h33, 32'h22, 32'h11}; fwd_data_ok = 3'b111;
        #1 chk("prio_ready", 32'(in_ready), 32'd1);
        step();
        chk("prio_valid", 32'(out_valid), 32'd1);
        chk("prio_rs", out_rs_value, 32'h11);
        chk("prio_pc", out_pc, 32'h200);

        // Load-use on rt: two stall cycles, then data arrives
        idle(); issue(32'h300, 0); in_rt = 8; in_use_rt = 1;
        fwd_wen = 3'b001; fwd_dest = {5'd0, 5'd0, 5'd8}; fwd_data = {64'd0, 32'hDEAD};
        fwd_data_ok = 3'b000;
        #1 chk("lu_stall1", 32'(in_ready), 32'd0);
        step();
        chk("lu_stall2", 32'(in_ready), 32'd0);
        step();
        fwd_data_ok = 3'b001;
        #1 chk("lu_ready", 32'(in_ready), 32'd1);
        step();
        chk("lu_rt", out_rt_value, 32'hDEAD);
        chk("lu_pc", out_pc, 32'h300);

        // Older ok match must not hide a younger unready one
        idle(); issue(32'h380, 0); in_rs = 9; in_use_rs = 1;
        fwd_wen = 3'b101; fwd_dest = {5'd9, 5'd0, 5'd9}; fwd_data_ok = 3'b100;
        #1 chk("young_stall", 32'(in_ready), 32'd0);
        step();

        // $zero never forwards nor stalls
        idle(); issue(32'h3c0, 0); in_rs = 0; in_use_rs = 1;
        fwd_wen = 3'b001; fwd_dest = 0; fwd_data = {64'd0, 32'hFFFF}; fwd_data_ok = 0;
        #1 chk("zero_ready", 32'(in_ready), 32'd1);
        step();
        chk("zero_rs", out_rs_value, 32'd0);

        // Backpressure: hold for 3 cycles, then capture same cycle out_ready rises
        idle(); issue(32'h400, 0); step();
        issue(32'h404, 0); out_ready = 0;
        for (int k = 0; k < 3; k++) begin
            #1 chk("bp_ready", 32'(in_ready), 32'd0);
            step();
            chk("bp_hold_pc", out_pc, 32'h400);
        end
        out_ready = 1;
        #1 chk("bp_release", 32'(in_ready), 32'd1);
        step();
        chk("bp_new_pc", out_pc, 32'h404);
        chk("bp_new_valid", 32'(out_valid), 32'd1);

        // Delay slot survives a stall
        idle(); issue(32'h100, 1); step();
        issue(32'h104, 0); in_rs = 3; in_use_rs = 1;
        fwd_wen = 3'b010; fwd_dest = {5'd0, 5'd3, 5'd0}; fwd_data_ok = 3'b000;
        step(); step();
        fwd_data_ok = 3'b010; step();
        chk("ds_pc", out_pc, 32'h104);
        chk("ds_delay", 32'(out_in_delay), 32'd1);
        idle(); issue(32'h108, 0); step();
        chk("ds_after", 32'(out_in_delay), 32'd0);

        // Flush after a jbr clears the pending delay slot
        issue(32'h10c, 1); step();
        idle(); flush = 1; step();
        chk("fl_valid", 32'(out_valid), 32'd0);
        flush = 0; issue(32'h110, 0); step();
        chk("fl_delay", 32'(out_in_delay), 32'd0);

        // Flush and accept in the same cycle, with a hazard present
        idle(); issue(32'h500, 0); in_rs = 4; in_use_rs = 1;
        fwd_wen = 3'b001; fwd_dest = {10'd0, 5'd4}; fwd_data_ok = 3'b000; flush = 1;
`ifdef ID_STALL_CNT_EN
        cnt_snap = stall_cnt;
`else
        cnt_snap = 0;
`endif
        #1 chk("fa_ready", 32'(in_ready), 32'd0);
        step();
        chk("fa_valid", 32'(out_valid), 32'd0);
`ifdef ID_STALL_CNT_EN
        chk("fa_cnt", stall_cnt, cnt_snap);
`endif

        // Reset while stalled drops everything, including a pending delay slot
        idle(); issue(32'h600, 1); step();
        issue(32'h604, 0); in_rs = 4; in_use_rs = 1;
        fwd_wen = 3'b001; fwd_dest = {10'd0, 5'd4}; fwd_data_ok = 0;
        step();
        resetn = 0; step(); resetn = 1;
        chk("rs_valid", 32'(out_valid), 32'd0);
        chk("rs_pc", out_pc, 32'd0);
        idle(); step();
        chk("rs_no_capture", 32'(out_valid), 32'd0);
        issue(32'h608, 0); step();
        chk("rs_delay", 32'(out_in_delay), 32'd0);

        // Randomized traffic, checked by the per-cycle compare process
        for (int k = 0; k < 4000; k++) begin
            resetn      = ($urandom % 200) != 0;
            in_valid    = ($urandom % 4) != 0;
            in_pc       = $urandom;
            in_rs       = 5'($urandom % 8);
            in_rt       = 5'($urandom % 8);
            in_use_rs   = 1'($urandom);
            in_use_rt   = 1'($urandom);
            in_is_jbr   = ($urandom % 4) == 0;
            rf_rs_value = $urandom;
            rf_rt_value = $urandom;
            fwd_wen     = 3'($urandom);
            for (int i = 0; i < N; i++) begin
                fwd_dest[5*i +: 5]  = 5'($urandom % 8);
                fwd_data[32*i +: 32] = $urandom;
                fwd_data_ok[i]      = ($urandom % 3) != 0;
            end
            flush     = ($urandom % 16) == 0;
            out_ready = ($urandom % 4) != 0;
            step();
        end

        chk_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/id_operand_fwd.md
Name: id_operand_fwd

Overview:
- Parametrised successor ID-stage operand unit.
- Replaces stall-until-writeback with a forwarding network over N_FWD younger pipeline stages.
- Stalls only when a matching producer's data is not yet available (load-use, mul/div).
- Registers results into the ID/EXE boundary with a valid/allow-in handshake, and tracks branch delay slots across stalls and flushes.

Parameters:
N_FWD, 3, number of forwarding sources; index 0 = youngest (EXE), N_FWD-1 = oldest (WB)
DW, 32, operand and data width
PCW, 32, PC width

Ports:
clk  input  1  clock
resetn  input  1  synchronous reset, active low
in_valid  input  1  decoded instruction present in ID
in_ready  output  1  ID may retire instruction this cycle (ID_over equivalent)
in_pc  input  PCW  instruction PC
in_rs  input  5  rs register index
in_rt  input  5  rt register index
in_use_rs  input  1  instruction reads rs
in_use_rt  input  1  instruction reads rt
in_is_jbr  input  1  instruction is jump/branch (next accepted instruction is delay slot)
rf_rs_value  input  DW  register file read data for rs
rf_rt_value  input  DW  register file read data for rt
fwd_wen  input  N_FWD  source i holds valid instruction writing a GPR
fwd_dest  input  5*N_FWD  destination of source i, bits [5i+4:5i]
fwd_data  input  DW*N_FWD  result of source i, bits [DW*i+DW-1:DW*i]
fwd_data_ok  input  N_FWD  result of source i is final
flush  input  1  exception/ERET cancel
out_valid  output  1  ID/EXE register holds valid instruction
out_ready  input  1  EXE accepts (EXE allow-in)
out_pc  output  PCW  registered PC
out_rs_value  output  DW  resolved rs operand
out_rt_value  output  DW  resolved rt operand
out_in_delay  output  1  registered instruction sits in a branch delay slot
fwd_rs_value  output  DW  combinational resolved rs, for branch compare in ID
fwd_rt_value  output  DW  combinational resolved rt, for branch compare in ID

Behaviour:
- Reset (resetn=0 at posedge clk):
  - out_valid=0, out_pc=0, out_rs_value=0, out_rt_value=0, out_in_delay=0.
  - delay-pending flag=0.
- Operand resolution, per operand (rs shown; rt identical), combinational:
  - Match i = fwd_wen[i] & (fwd_dest_i == in_rs) & (in_rs != 0).
  - Lowest-index match wins.
  - Value: fwd_data_i of the winning match; rf_rs_value if no match; 0 if in_rs==0.
- Hazard:
  - rs_wait = in_use_rs & winner exists & ~fwd_data_ok[winner].
  - rt_wait likewise.
  - An older match with data_ok=1 does not suppress a stall caused by a younger match with data_ok=0.
- Handshake:
  - in_ready = ~rs_wait & ~rt_wait & (~out_valid | out_ready) & ~flush.
  - accept = in_valid & in_ready.
- Pipeline register, priority flush > accept > drain:
  - flush: out_valid<=0.
  - accept: out_valid<=1; capture pc and resolved operands.
  - out_valid & out_ready & ~accept: out_valid<=0.
  - Otherwise hold all outputs stable.
- Latency: 1 cycle from accept to out_valid.
- Delay slot:
  - delay-pending flag <= in_is_jbr on each accept.
  - Accepted instruction's out_in_delay <= delay-pending flag (pre-update value).
  - Stalls do not alter the flag.
  - flush clears the flag.
  - Jbr in delay slot: out_in_delay=1 and flag set again.
- in_valid=0: no state change except drain/flush.
- Reset mid-stall: all state returns to reset values; no pending capture survives.

Optional Feature:
- Macro: ID_STALL_CNT_EN.
- Defined: adds output stall_cnt[31:0].
  - Increments by 1 each cycle with in_valid & (rs_wait | rt_wait) & ~flush.
  - Wraps 0xFFFFFFFF -> 0.
  - Reset value 0.
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- Forward priority: fwd_wen=3'b111, all fwd_dest=5, data {EXE=0x11, MEM=0x22, WB=0x33}, all ok, in_rs=5 -> next cycle out_rs_value=0x11, out_valid=1.
- Load-use: EXE dest=8, data_ok=0 for 2 cycles then 1 (data 0xDEAD), in_rt=8, use_rt=1 -> in_ready=0 for 2 cycles; accept on 3rd; out_rt_value=0xDEAD.
- $zero: in_rs=0, EXE dest=0 with data 0xFFFF -> out_rs_value=0, no stall even if data_ok=0.
- Backpressure: out_valid=1, out_ready=0 for 3 cycles -> in_ready=0; outputs stable; on out_ready=1 the new instruction is captured the same cycle.
- Delay slot: accept jbr at pc 0x100, stall 2 cycles, accept 0x104 -> out_in_delay=1 for 0x104; 0x108 -> 0. Flush after jbr -> next accepted out_in_delay=0.
- Flush vs accept same cycle: in_valid=1, no hazard, flush=1 -> out_valid=0 next cycle, in_ready=0; with ID_STALL_CNT_EN, counter unchanged.
